// File: rtl/aes_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_arb_pkg
// Brief   : Shared types, widths and index helpers for the AES request arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package aes_arb_pkg;

    localparam int AES_BLK_W = 128;
    localparam int N_REQ     = 2;
    localparam int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

    // With two requesters the successor of the winner is the non-winner.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : aes_rr_pick
// Brief   : Combinational round-robin picker; ptr has priority, then ptr+1, ...
// Revision: 1.0 - initial release
// ============================================================================
module aes_rr_pick
    import aes_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    logic [N_REQ-1:0]   req_rot_w;
    logic [N_REQ-1:0]   gnt_rot_w;
    logic [2*N_REQ-1:0] gnt_dbl_w;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_rot_w = N_REQ'({req, req} >> ptr);
        gnt_rot_w = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot_w[i]) begin
                gnt_rot_w = N_REQ'(1) << i;
            end
        end
        gnt_dbl_w = {gnt_rot_w, gnt_rot_w} << ptr;
        grant     = gnt_dbl_w[2*N_REQ-1:N_REQ];
    end

endmodule
`default_nettype wire

// File: rtl/aes_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : aes_req_arbiter
// Brief   : Two-requester round-robin front end for a single AES core.
//           Optional RUN timeout enabled by macro AES_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module aes_req_arbiter
    import aes_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 AES_clk,
    input  logic                 AES_rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [AES_BLK_W-1:0] req_data_0,
    input  logic [AES_BLK_W-1:0] req_key_0,
    input  logic [AES_BLK_W-1:0] req_data_1,
    input  logic [AES_BLK_W-1:0] req_key_1,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [AES_BLK_W-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 AES_en,
    output logic [AES_BLK_W-1:0] AES_data_in,
    output logic [AES_BLK_W-1:0] AES_key_in,
    input  logic [AES_BLK_W-1:0] AES_data_out,
    input  logic                 AES_data_out_valid
);

    arb_state_e             state_q,     state_d;
    logic [IDX_W-1:0]       rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]       owner_q,     owner_d;
    logic                   aes_en_q,    aes_en_d;
    logic [AES_BLK_W-1:0]   data_in_q,   data_in_d;
    logic [AES_BLK_W-1:0]   key_in_q,    key_in_d;
    logic [N_REQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [AES_BLK_W-1:0]   rsp_data_q,  rsp_data_d;

    logic [N_REQ-1:0]       grant_w;
    logic [IDX_W-1:0]       grant_idx_w;
    logic                   accept_w;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic                   rsp_err_q,   rsp_err_d;
    logic [TMO_W-1:0]       tmo_cnt_q,   tmo_cnt_d;
`else
    // Timeout support is compiled out; keep the parameter referenced.
    logic [31:0]            unused_timeout_cyc;
    assign unused_timeout_cyc = TIMEOUT_CYC;
`endif

    aes_rr_pick u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant_w)
    );

    always_comb begin
        req_ready   = '0;
        if (state_q == IDLE && !AES_rst) begin
            req_ready = grant_w;
        end
        grant_idx_w = onehot_to_idx(grant_w);
        accept_w    = |(req_valid & req_ready);
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        aes_en_d    = aes_en_q;
        data_in_d   = data_in_q;
        key_in_d    = key_in_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
`ifdef AES_ARB_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
        tmo_cnt_d   = tmo_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept_w) begin
                    owner_d   = grant_idx_w;
                    rr_ptr_d  = next_idx(grant_idx_w);
                    data_in_d = grant_w[1] ? req_data_1 : req_data_0;
                    key_in_d  = grant_w[1] ? req_key_1  : req_key_0;
                    aes_en_d  = 1'b1;
                    state_d   = RUN;
`ifdef AES_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            RUN: begin
                // A result arriving on the final timeout cycle still wins.
                if (AES_data_out_valid) begin
                    rsp_valid_d = idx_to_onehot(owner_q);
                    rsp_data_d  = AES_data_out;
                    aes_en_d    = 1'b0;
                    state_d     = RESP;
`ifdef AES_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_valid_d = idx_to_onehot(owner_q);
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    aes_en_d    = 1'b0;
                    state_d     = RESP;
                end else begin
                    tmo_cnt_d   = tmo_cnt_q + TMO_W'(1);
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            aes_en_q    <= 1'b0;
            data_in_q   <= '0;
            key_in_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            aes_en_q    <= aes_en_d;
            data_in_q   <= data_in_d;
            key_in_q    <= key_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef AES_ARB_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign AES_en      = aes_en_q;
    assign AES_data_in = data_in_q;
    assign AES_key_in  = key_in_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
`ifdef AES_ARB_TIMEOUT_EN
    assign rsp_err     = rsp_err_q;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_req_arbiter
// Brief   : Self-checking bench for aes_req_arbiter with a behavioural core.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_req_arbiter;

    localparam int TMO = 8;

    logic         AES_clk = 1'b0;
    logic         AES_rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_data_0, req_key_0, req_data_1, req_key_1;
    logic [1:0]   rsp_valid;
    logic [127:0] rsp_data;
    logic         rsp_err;
    logic         AES_en;
    logic [127:0] AES_data_in, AES_key_in;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;

    logic         core_vld, man_vld;
    logic [127:0] core_out;
    bit           core_on;
    int           core_lat;

    int           errors = 0;
    int           checks = 0;
    int           model_ptr = 0;
    logic [127:0] exp_last = '0;

    assign AES_data_out_valid = core_vld | man_vld;
    assign AES_data_out       = core_out;

    always #5 AES_clk = ~AES_clk;

    aes_req_arbiter #(.TIMEOUT_CYC(TMO)) dut (
        .AES_clk            (AES_clk),
        .AES_rst            (AES_rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_data_0         (req_data_0),
        .req_key_0          (req_key_0),
        .req_data_1         (req_data_1),
        .req_key_1          (req_key_1),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .rsp_err            (rsp_err),
        .AES_en             (AES_en),
        .AES_data_in        (AES_data_in),
        .AES_key_in         (AES_key_in),
        .AES_data_out       (AES_data_out),
        .AES_data_out_valid (AES_data_out_valid)
    );

    // Stand-in cipher: any fixed mixing of data and key is enough here.
    function automatic logic [127:0] fake_core(input logic [127:0] d, input logic [127:0] k);
        return d ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    endfunction

    function automatic int pick(input logic [1:0] v, input int ptr);
        if (v == 2'b11) return ptr;
        return v[1] ? 1 : 0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Core: answers core_lat enabled cycles after AES_en rises, once per operation.
    initial begin : core_model
        int cnt;
        bit fired;
        core_vld = 1'b0;
        core_out = '0;
        cnt      = 0;
        fired    = 1'b0;
        forever begin
            @(posedge AES_clk);
            #1;
            core_vld = 1'b0;
            if (!AES_en) begin
                cnt   = 0;
                fired = 1'b0;
            end else if (!fired) begin
                cnt++;
                if (core_on && cnt >= core_lat) begin
                    core_vld = 1'b1;
                    core_out = fake_core(AES_data_in, AES_key_in);
                    fired    = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge AES_clk);
        #2;
    endtask

    task automatic test_reset();
        AES_rst = 1'b1; req_valid = 2'b11;
        req_data_0 = rnd128(); req_key_0 = rnd128(); req_data_1 = rnd128(); req_key_1 = rnd128();
        step(); step();
        checks++; if (AES_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", AES_en); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        checks++; if (rsp_data !== 128'd0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        checks++; if (AES_data_in !== 128'd0 || AES_key_in !== 128'd0) begin errors++; $display("FAIL reset_core_in: got %h/%h want 0/0", AES_data_in, AES_key_in); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        AES_rst = 1'b0; req_valid = 2'b00; model_ptr = 0;
        step();
    endtask

    task automatic test_single();
        logic [127:0] d, k, e;
        int lat;
        d = 128'h00000086_00000000_00000000_00000000;
        k = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
        e = fake_core(d, k);
        lat = 4; core_lat = lat; core_on = 1'b1;
        req_data_0 = d; req_key_0 = k; req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
        model_ptr = 1;
        step();
        req_valid = 2'b00;
        for (int i = 0; i < lat; i++) begin
            checks++; if (AES_en !== 1'b1 || rsp_valid !== 2'b00) begin errors++; $display("FAIL single_run: cyc %0d en %b rsp %b want 1/00", i, AES_en, rsp_valid); end
            checks++; if (AES_data_in !== d || AES_key_in !== k) begin errors++; $display("FAIL single_core_in: got %h/%h want %h/%h", AES_data_in, AES_key_in, d, k); end
            step();
        end
        checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp: got %b/%b want 01/0", rsp_valid, rsp_err); end
        checks++; if (rsp_data !== e) begin errors++; $display("FAIL single_rsp_data: got %h want %h", rsp_data, e); end
        checks++; if (AES_en !== 1'b0) begin errors++; $display("FAIL single_en_low: got %b want 0", AES_en); end
        exp_last = e;
        step();
        checks++; if (rsp_valid !== 2'b00 || rsp_data !== e) begin errors++; $display("FAIL single_hold: got %b/%h want 00/%h", rsp_valid, rsp_data, e); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] d0, k0, d1, k1, e;
        logic [1:0] g;
        int w, lat;
        AES_rst = 1'b1; step(); AES_rst = 1'b0; model_ptr = 0;
        d0 = rnd128(); k0 = rnd128(); d1 = rnd128(); k1 = rnd128();
        req_data_0 = d0; req_key_0 = k0; req_data_1 = d1; req_key_1 = k1;
        req_valid = 2'b11;
        for (int op = 0; op < 4; op++) begin
            w = op % 2;
            g = (w == 1) ? 2'b10 : 2'b01;
            lat = $urandom_range(1, 5); core_lat = lat;
            #1;
            checks++; if (req_ready !== g) begin errors++; $display("FAIL b2b_grant: op %0d got %b want %b", op, req_ready, g); end
            model_ptr = 1 - w;
            step();
            checks++; if (AES_en !== 1'b1 || AES_data_in !== (w == 1 ? d1 : d0)) begin errors++; $display("FAIL b2b_start: op %0d en %b data %h", op, AES_en, AES_data_in); end
            for (int i = 0; i < lat; i++) step();
            e = fake_core(w == 1 ? d1 : d0, w == 1 ? k1 : k0);
            checks++; if (rsp_valid !== g || rsp_data !== e) begin errors++; $display("FAIL b2b_rsp: op %0d got %b/%h want %b/%h", op, rsp_valid, rsp_data, g, e); end
            exp_last = e;
            step();
            checks++; if (AES_en !== 1'b0 || rsp_valid !== 2'b00) begin errors++; $display("FAIL b2b_gap: op %0d en %b rsp %b want 0/00", op, AES_en, rsp_valid); end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_hold_inputs();
        logic [127:0] d, k, e;
        int lat;
        d = rnd128(); k = rnd128(); e = fake_core(d, k);
        lat = 5; core_lat = lat;
        req_data_0 = d; req_key_0 = k; req_valid = 2'b01;
        #1;
        model_ptr = 1 - pick(2'b01, model_ptr);
        step();
        for (int i = 0; i < lat; i++) begin
            checks++; if (AES_data_in !== d || AES_key_in !== k || AES_en !== 1'b1) begin errors++; $display("FAIL hold_core_in: cyc %0d got %h/%h want %h/%h", i, AES_data_in, AES_key_in, d, k); end
            req_data_0 = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
            req_key_0  = rnd128();
            req_valid  = 2'($urandom_range(0, 3));
            step();
        end
        req_valid = 2'b00;
        checks++; if (rsp_valid !== 2'b01 || rsp_data !== e) begin errors++; $display("FAIL hold_rsp: got %b/%h want 01/%h", rsp_valid, rsp_data, e); end
        exp_last = e;
        step();
    endtask

    task automatic test_idle_valid();
        logic [127:0] d, k, e;
        req_valid = 2'b00; man_vld = 1'b1;
        step();
        man_vld = 1'b0;
        checks++; if (rsp_valid !== 2'b00 || AES_en !== 1'b0 || rsp_data !== exp_last) begin errors++; $display("FAIL idle_valid: rsp %b en %b data %h want 00/0/%h", rsp_valid, AES_en, rsp_data, exp_last); end
        step();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL idle_valid_late: got %b want 00", rsp_valid); end
        d = rnd128(); k = rnd128(); e = fake_core(d, k);
        core_lat = 1;
        req_data_1 = d; req_key_1 = k; req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL idle_still_idle: got %b want 10", req_ready); end
        model_ptr = 1 - pick(2'b10, model_ptr);
        step();
        req_valid = 2'b00;
        step();
        checks++; if (rsp_valid !== 2'b10 || rsp_data !== e) begin errors++; $display("FAIL idle_op_rsp: got %b/%h want 10/%h", rsp_valid, rsp_data, e); end
        exp_last = e;
        step();
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] d0, k0, e;
        core_on = 1'b0;
        req_data_1 = rnd128(); req_key_1 = rnd128(); req_valid = 2'b10;
        #1;
        step();
        req_valid = 2'b00;
        step(); step();
        checks++; if (AES_en !== 1'b1) begin errors++; $display("FAIL mid_run_en: got %b want 1", AES_en); end
        AES_rst = 1'b1; req_valid = 2'b11;
        d0 = rnd128(); k0 = rnd128(); e = fake_core(d0, k0);
        req_data_0 = d0; req_key_0 = k0;
        step();
        checks++; if (AES_en !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin errors++; $display("FAIL mid_run_abort: en %b rsp %b rdy %b want 0/00/00", AES_en, rsp_valid, req_ready); end
        AES_rst = 1'b0; model_ptr = 0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_run_regrant: got %b want 01", req_ready); end
        model_ptr = 1;
        core_on = 1'b1; core_lat = 2;
        step();
        req_valid = 2'b00;
        checks++; if (rsp_valid !== 2'b00 || AES_data_in !== d0) begin errors++; $display("FAIL mid_run_restart: rsp %b data %h want 00/%h", rsp_valid, AES_data_in, d0); end
        step(); step();
        checks++; if (rsp_valid !== 2'b01 || rsp_data !== e) begin errors++; $display("FAIL mid_run_rsp: got %b/%h want 01/%h", rsp_valid, rsp_data, e); end
        exp_last = e;
        step();
    endtask

    task automatic test_timeout();
        logic [127:0] d, k, e;
        d = rnd128(); k = rnd128(); e = fake_core(d, k);
        core_on = 1'b0;
        req_data_0 = d; req_key_0 = k; req_valid = 2'b01;
        #1;
        model_ptr = 1 - pick(2'b01, model_ptr);
        step();
        req_valid = 2'b00;
`ifdef AES_ARB_TIMEOUT_EN
        for (int i = 0; i < TMO; i++) begin
            checks++; if (AES_en !== 1'b1 || rsp_valid !== 2'b00) begin errors++; $display("FAIL tmo_wait: cyc %0d en %b rsp %b want 1/00", i, AES_en, rsp_valid); end
            step();
        end
        checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_data !== 128'd0) begin errors++; $display("FAIL tmo_rsp: got %b/%b/%h want 01/1/0", rsp_valid, rsp_err, rsp_data); end
        checks++; if (AES_en !== 1'b0) begin errors++; $display("FAIL tmo_en: got %b want 0", AES_en); end
        step();
        core_on = 1'b1; core_lat = TMO;
        req_data_1 = d; req_key_1 = k; req_valid = 2'b10;
        #1;
        model_ptr = 1 - pick(2'b10, model_ptr);
        step();
        req_valid = 2'b00;
        for (int i = 0; i < TMO; i++) step();
        checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b0 || rsp_data !== e) begin errors++; $display("FAIL tmo_last_valid: got %b/%b/%h want 10/0/%h", rsp_valid, rsp_err, rsp_data, e); end
`else
        for (int i = 0; i < 40; i++) begin
            checks++; if (AES_en !== 1'b1 || rsp_valid !== 2'b00) begin errors++; $display("FAIL no_tmo_wait: cyc %0d en %b rsp %b want 1/00", i, AES_en, rsp_valid); end
            step();
        end
        core_on = 1'b1;
        step(); step();
        checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_data !== e) begin errors++; $display("FAIL no_tmo_rsp: got %b/%b/%h want 01/0/%h", rsp_valid, rsp_err, rsp_data, e); end
`endif
        exp_last = e;
        step();
    endtask

    task automatic test_random();
        logic [127:0] d0, k0, d1, k1, ed, ek;
        logic [1:0] v, g;
        int w, lat;
        core_on = 1'b1;
        for (int op = 0; op < 12; op++) begin
            d0 = rnd128(); k0 = rnd128(); d1 = rnd128(); k1 = rnd128();
            v = 2'($urandom_range(1, 3));
            lat = $urandom_range(1, 6); core_lat = lat;
            req_data_0 = d0; req_key_0 = k0; req_data_1 = d1; req_key_1 = k1; req_valid = v;
            w  = pick(v, model_ptr);
            g  = (w == 1) ? 2'b10 : 2'b01;
            ed = (w == 1) ? d1 : d0;
            ek = (w == 1) ? k1 : k0;
            #1;
            checks++; if (req_ready !== g) begin errors++; $display("FAIL rnd_grant: op %0d v %b got %b want %b", op, v, req_ready, g); end
            model_ptr = 1 - w;
            step();
            for (int i = 0; i < lat; i++) begin
                checks++; if (AES_en !== 1'b1 || AES_data_in !== ed || AES_key_in !== ek || req_ready !== 2'b00) begin errors++; $display("FAIL rnd_run: op %0d cyc %0d en %b rdy %b data %h want %h", op, i, AES_en, req_ready, AES_data_in, ed); end
                req_valid = 2'($urandom_range(0, 3));
                req_data_0 = rnd128(); req_data_1 = rnd128();
                step();
            end
            req_valid = 2'b00;
            checks++; if (rsp_valid !== g || rsp_err !== 1'b0 || rsp_data !== fake_core(ed, ek)) begin errors++; $display("FAIL rnd_rsp: op %0d got %b/%b/%h want %b/0/%h", op, rsp_valid, rsp_err, rsp_data, g, fake_core(ed, ek)); end
            step();
            checks++; if (AES_en !== 1'b0 || rsp_valid !== 2'b00) begin errors++; $display("FAIL rnd_gap: op %0d en %b rsp %b want 0/00", op, AES_en, rsp_valid); end
        end
    endtask

    initial begin
        AES_rst = 1'b1; req_valid = 2'b00; man_vld = 1'b0;
        core_on = 1'b1; core_lat = 1;
        req_data_0 = '0; req_key_0 = '0; req_data_1 = '0; req_key_1 = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_inputs();
        test_idle_valid();
        test_reset_mid_run();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/aes_req_arbiter.md
AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 64, which is the maximum number of RUN cycles to wait for a core result.
REQ-002 The block SHALL have port AES_clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port AES_rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port req_valid, input, 2 bits, the per-requester request strobe.
REQ-005 The block SHALL have port req_ready, output, 2 bits, the per-requester accept.
REQ-006 The block SHALL have port req_data_0, input, 128 bits, the plaintext from requester 0.
REQ-007 The block SHALL have port req_key_0, input, 128 bits, the key from requester 0.
REQ-008 The block SHALL have port req_data_1, input, 128 bits, the plaintext from requester 1.
REQ-009 The block SHALL have port req_key_1, input, 128 bits, the key from requester 1.
REQ-010 The block SHALL have port rsp_valid, output, 2 bits, a one-hot response strobe to the owning requester.
REQ-011 The block SHALL have port rsp_data, output, 128 bits, the ciphertext, qualified by rsp_valid.
REQ-012 The block SHALL have port rsp_err, output, 1 bit, the timeout flag, qualified by rsp_valid.
REQ-013 The block SHALL have port AES_en, output, 1 bit, the core enable, held high for the whole operation.
REQ-014 The block SHALL have port AES_data_in, output, 128 bits, the plaintext to the core.
REQ-015 The block SHALL have port AES_key_in, output, 128 bits, the key to the core.
REQ-016 The block SHALL have port AES_data_out, input, 128 bits, the core result.
REQ-017 The block SHALL have port AES_data_out_valid, input, 1 bit, the core result strobe.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and RESP.
REQ-019 In IDLE, req_ready SHALL be the combinational one-hot grant among req_valid; in RUN and RESP, req_ready SHALL be 0.
REQ-020 Grant SHALL be round-robin: rr_ptr wins when both requesters are valid; after each accept, rr_ptr SHALL become the index of the non-winner.
REQ-021 On accept (req_valid and req_ready high in cycle t), the block SHALL latch data, key and owner, then enter RUN; AES_en, AES_data_in and AES_key_in SHALL be driven from the latches starting at t+1.
REQ-022 In RUN, AES_en SHALL stay at 1 and AES_data_in/AES_key_in SHALL stay stable; requester input changes SHALL have no effect.
REQ-023 On AES_data_out_valid in RUN cycle v, the block SHALL capture AES_data_out and enter RESP; in cycle v+1, AES_en SHALL be 0, rsp_valid[owner] SHALL be 1 for exactly one cycle, rsp_err SHALL be 0, and rsp_data SHALL hold the captured value.
REQ-024 RESP SHALL return to IDLE; the earliest next accept SHALL be v+2, which guarantees at least one AES_en-low cycle between operations.
REQ-025 Responses SHALL have no backpressure; rsp_data SHALL hold its value until the next response.
REQ-026 AES_data_out_valid outside RUN SHALL be ignored.
REQ-027 A req_valid deasserted before accept SHALL be dropped silently.
REQ-028 All outputs except req_ready SHALL be registered.

Reset
REQ-029 While AES_rst is high, the block SHALL force: state IDLE, rr_ptr 0, latches 0, AES_en 0, AES_data_in/AES_key_in 0, rsp_valid 0, rsp_data 0, rsp_err 0, req_ready 0.
REQ-030 A reset during RUN or RESP SHALL abort the operation: no response is issued, and AES_en SHALL be low in the cycle after reset is sampled.

Configuration
REQ-031 With macro AES_ARB_TIMEOUT_EN defined, a RUN cycle counter SHALL run; if it reaches TIMEOUT_CYC with no valid, the block SHALL enter RESP with rsp_err 1 and rsp_data 0. A valid and the timeout in the same cycle SHALL resolve as valid.
REQ-032 Without AES_ARB_TIMEOUT_EN, the counter SHALL be absent, RUN SHALL wait indefinitely, and rsp_err SHALL be tied to 0.

Structure
REQ-033 Package aes_arb_pkg SHALL hold the state enum, AES_BLK_W=128 and N_REQ=2.
REQ-034 The round-robin grant logic SHALL be sub-module aes_rr_pick (inputs: req, ptr; output: one-hot grant).

Verification
REQ-035 Single request: req 0 with data 00000086_00000000_00000000_00000000 and key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc -> AES_en high from t+1 until valid; rsp_valid=01, rsp_data equals the core output, rsp_err 0.
REQ-036 Both requesters valid continuously after reset -> grants alternate 0,1,0,1, with an AES_en-low gap of at least one cycle between operations.
REQ-037 Change req_data_0 to a6f2daeb_140fa720_529e75d5_21cbc681 during RUN -> AES_data_in unchanged, and the response corresponds to the originally latched block.
REQ-038 Assert AES_rst mid-RUN -> AES_en 0 in the next cycle, no rsp_valid, and the next grant goes to requester 0.
REQ-039 With AES_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, core valid held low -> rsp_valid[owner]=1, rsp_err=1, rsp_data=0 after 8 RUN cycles; a valid on cycle 8 -> rsp_err 0.
REQ-040 AES_data_out_valid pulsed while in IDLE -> no rsp_valid and no state change.
